// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage: decodes aluop/funct into the ALU function code and
// hands it to EX through a 2-entry skid buffer with fully registered valid/ready.
module alu_ctrl_issue #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; the producer holds payload stable while valid=1 and ready=0.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2:0]         main_code_q;
  logic               main_ill_q;
  logic [TAG_W-1:0]   main_tag_q;
  logic [2:0]         skid_code_q;
  logic               skid_ill_q;
  logic [TAG_W-1:0]   skid_tag_q;
  logic [CNT_W-1:0]   illegal_cnt_q;

  logic [2:0]         dec_code;
  logic               dec_ill;
  logic               push;
  logic               pop;

  always_comb begin
    dec_code = 3'b010;
    dec_ill  = 1'b0;
    case (aluop)
      2'b00: dec_code = 3'b010;
      2'b01: dec_code = 3'b110;
      2'b11: dec_code = 3'b001;
      default: begin
        case (funct)
          6'b100000: dec_code = 3'b010;
          6'b100010: dec_code = 3'b110;
          6'b100100: dec_code = 3'b000;
          6'b100101: dec_code = 3'b001;
          6'b101010: dec_code = 3'b111;
          default: begin
            dec_code = 3'b010;
            dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      main_code_q   <= 3'b000;
      main_ill_q    <= 1'b0;
      main_tag_q    <= '0;
      skid_code_q   <= 3'b000;
      skid_ill_q    <= 1'b0;
      skid_tag_q    <= '0;
      illegal_cnt_q <= '0;
    end else if (flush) begin
      // Flush wins over push and pop; the counter keeps its history.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (pop && main_ill_q && (illegal_cnt_q != {CNT_W{1'b1}}))
        illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_code_q <= dec_code;
            main_ill_q  <= dec_ill;
            main_tag_q  <= in_tag;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_code_q <= dec_code;
            main_ill_q  <= dec_ill;
            main_tag_q  <= in_tag;
          end else if (push) begin
            skid_code_q <= dec_code;
            skid_ill_q  <= dec_ill;
            skid_tag_q  <= in_tag;
            state_q     <= TWO;
            in_ready_q  <= 1'b0;
          end else if (pop) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            main_code_q <= skid_code_q;
            main_ill_q  <= skid_ill_q;
            main_tag_q  <= skid_tag_q;
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alucontrol  = main_code_q;
  assign illegal     = main_ill_q;
  assign out_tag     = main_tag_q;
  assign illegal_cnt = illegal_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: scoreboard of decoded ops plus
// directed checks for back-pressure, saturation, flush and async reset.
module tb_alu_ctrl_issue;
  localparam int TAG_W = 5;
  localparam int CNT_W = 8;
  localparam int W     = 3 + 1 + TAG_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       aluop = 2'b00;
  logic [5:0]       funct = 6'b000000;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       alucontrol;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] illegal_cnt;
  logic [1:0]       state_dbg;

  int               total = 0;
  int               bad = 0;
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [CNT_W-1:0] cnt_saved;
  bit               auto_rdy = 1'b0;

  alu_ctrl_issue #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .alucontrol(alucontrol), .illegal(illegal), .out_tag(out_tag),
    .illegal_cnt(illegal_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference decode: {code, illegal}
  function automatic logic [3:0] ref_dec(input logic [1:0] a, input logic [5:0] f);
    if (a == 2'b00) return {3'd2, 1'b0};
    if (a == 2'b01) return {3'd6, 1'b0};
    if (a == 2'b11) return {3'd1, 1'b0};
    case (f)
      6'd32: return {3'd2, 1'b0};
      6'd34: return {3'd6, 1'b0};
      6'd36: return {3'd0, 1'b0};
      6'd37: return {3'd1, 1'b0};
      6'd42: return {3'd7, 1'b0};
      default: return {3'd2, 1'b1};
    endcase
  endfunction

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      check("illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("out_payload", 32'({alucontrol, illegal, out_tag}), 32'(e));
            if (e[TAG_W] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
          end
        end
        if (in_valid && in_ready) exp_q.push_back({ref_dec(aluop, funct), in_tag});
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [1:0] a, input logic [5:0] f, input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid = 1'b1;
    aluop = a;
    funct = f;
    in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      if (auto_rdy) out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drained", 32'(out_valid), 32'(0));
  endtask

  initial begin
    #22 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_alucontrol", 32'(alucontrol), 32'(0));
    check("rst_illegal", 32'(illegal), 32'(0));
    check("rst_out_tag", 32'(out_tag), 32'(0));
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'(0));

    // single op, then back-to-back stream
    out_ready = 1'b1;
    send(2'b10, 6'b101010, 5'd7);
    check("slt_valid", 32'(out_valid), 32'(1));
    check("slt_code", 32'(alucontrol), 32'(7));
    check("slt_illegal", 32'(illegal), 32'(0));
    check("slt_tag", 32'(out_tag), 32'(7));
    for (int i = 0; i < 8; i++) begin
      send(2'($urandom_range(0, 3)), 6'($urandom_range(32, 42)), 5'(i + 10));
      check("b2b_ready", 32'(in_ready), 32'(1));
    end
    drain();

    // back-pressure fills the skid entry
    out_ready = 1'b0;
    send(2'b00, 6'd0, 5'd1);
    send(2'b01, 6'd0, 5'd2);
    check("bp_in_ready", 32'(in_ready), 32'(0));
    check("bp_hold_code", 32'(alucontrol), 32'(2));
    check("bp_hold_tag", 32'(out_tag), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    check("bp_still_code", 32'(alucontrol), 32'(2));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", 32'(in_ready), 32'(1));
    check("bp_b_code", 32'(alucontrol), 32'(6));
    check("bp_b_tag", 32'(out_tag), 32'(2));
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'(0));

    // full decode sweep with random back-pressure
    auto_rdy = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int f = 0; f < 64; f++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        send(2'(a), 6'(f), 5'($urandom_range(0, 31)));
      end
    end
    drain();
    send(2'b10, 6'b000000, 5'd3);
    check("ill_code", 32'(alucontrol), 32'(2));
    check("ill_flag", 32'(illegal), 32'(1));

    // saturate the illegal counter
    for (int i = 0; i < 260; i++) send(2'b10, 6'b000001, 5'(i));
    drain();
    check("cnt_saturated", 32'(illegal_cnt), 32'(255));
    auto_rdy = 1'b0;

    // flush in TWO with an op offered
    out_ready = 1'b0;
    send(2'b00, 6'd0, 5'd4);
    send(2'b11, 6'd0, 5'd5);
    check("fl_two", 32'(in_ready), 32'(0));
    cnt_saved = exp_cnt;
    flush = 1'b1;
    in_valid = 1'b1;
    aluop = 2'b10;
    funct = 6'b100100;
    in_tag = 5'd31;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'(0));
    check("fl_in_ready", 32'(in_ready), 32'(1));
    check("fl_cnt", 32'(illegal_cnt), 32'(cnt_saved));
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fl_nothing", 32'(out_valid), 32'(0));

    // async reset mid-cycle while holding one op
    out_ready = 1'b0;
    send(2'b01, 6'd0, 5'd3);
    check("ar_one", 32'(out_valid), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'(0));
    check("ar_in_ready", 32'(in_ready), 32'(1));
    check("ar_alucontrol", 32'(alucontrol), 32'(0));
    check("ar_out_tag", 32'(out_tag), 32'(0));
    check("ar_illegal_cnt", 32'(illegal_cnt), 32'(0));
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b10, 6'b100100, 5'd9);
    check("ar_first_code", 32'(alucontrol), 32'(0));
    check("ar_first_tag", 32'(out_tag), 32'(9));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
